// File: rtl/bridge_dataslot_loader_if.sv
// ---------------------------------------------------------------------------
// bridge_dataslot_loader_if
// Bundles the bridge-side write bus, the dataslot control pulses, the core
// memory write port and the loader status outputs into one interface.
//
// Signals:
//   bridge_addr/bridge_wr/bridge_wr_data : bridge bus byte-address writes
//   slot_start/slot_id/slot_complete     : host dataslot write control pulses
//   mem_addr/mem_data/mem_valid/mem_ready: word write port toward core memory
//   busy/done/active_slot/word_count/overflow : load status
//
// Modports:
//   master : the side driving the bridge bus and accepting memory beats
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface bridge_dataslot_loader_if #(
    parameter int MEM_AW = 20
);
    logic [31:0]       bridge_addr;
    logic              bridge_wr;
    logic [31:0]       bridge_wr_data;
    logic              slot_start;
    logic [15:0]       slot_id;
    logic              slot_complete;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_valid;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic [15:0]       active_slot;
    logic [31:0]       word_count;
    logic              overflow;

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data,
        output slot_start, slot_id, slot_complete,
        output mem_ready,
        input  mem_addr, mem_data, mem_valid,
        input  busy, done, active_slot, word_count, overflow
    );

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data,
        input  slot_start, slot_id, slot_complete,
        input  mem_ready,
        output mem_addr, mem_data, mem_valid,
        output busy, done, active_slot, word_count, overflow
    );
endinterface

// File: rtl/bridge_dataslot_loader.sv
// ---------------------------------------------------------------------------
// bridge_dataslot_loader
// Captures bridge writes that land inside a configured address window while a
// host dataslot write is in progress, buffers them as {word address, data} in
// a small FIFO and drains them to a core memory write port. Reports a one-cycle
// done pulse once the host has completed the slot and every word has left.
//
// Ports:
//   clk     : bridge clock
//   reset_n : asynchronous active-low reset
//   bus     : bridge_dataslot_loader_if.slave (bridge bus, slot control,
//             memory write port, status)
// ---------------------------------------------------------------------------
module bridge_dataslot_loader #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] WINDOW_BYTES = 32'h0010_0000,
    parameter int          DEPTH        = 16,
    parameter bit          SWAP_BYTES   = 1'b1,
    parameter int          MEM_AW       = 20
) (
    input  logic                          clk,
    input  logic                          reset_n,
    bridge_dataslot_loader_if.slave       bus
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        DRAINING,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW:0]       wrPtr_q, wrPtr_d;
    logic [PW:0]       rdPtr_q, rdPtr_d;
    logic              outValid_q, outValid_d;
    logic [MEM_AW-1:0] outAddr_q, outAddr_d;
    logic [31:0]       outData_q, outData_d;
    logic [31:0]       wordCount_q, wordCount_d;
    logic [15:0]       activeSlot_q, activeSlot_d;
    logic              overflow_q, overflow_d;

    logic [MEM_AW-1:0] fifoAddr [DEPTH];
    logic [31:0]       fifoData [DEPTH];

    logic [31:0]       offset;
    logic              inWindow;
    logic [31:0]       pushData;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              handshake;
    logic              pushReq;
    logic              pushOk;
    logic [PW:0]       rdNext;

    // Window decode, byte reordering and FIFO status. The unsigned subtract
    // wraps addresses below the base to large values, so a single compare
    // against the window size covers both ends of the window. A word counts as
    // occupying the FIFO until the sink accepts it, so the presented head is
    // part of the DEPTH capacity and a same-cycle pop frees room for a push.
    always_comb begin
        offset    = bus.bridge_addr - BASE_ADDR;
        inWindow  = offset < WINDOW_BYTES;
        pushData  = SWAP_BYTES ? {bus.bridge_wr_data[7:0],   bus.bridge_wr_data[15:8],
                                  bus.bridge_wr_data[23:16], bus.bridge_wr_data[31:24]}
                               : bus.bridge_wr_data;
        fifoEmpty = (wrPtr_q == rdPtr_q);
        fifoFull  = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
        handshake = outValid_q && bus.mem_ready;
        pushReq   = (state_q == LOADING) && bus.bridge_wr && inWindow && !bus.slot_start;
        pushOk    = pushReq && (!fifoFull || handshake);
        rdNext    = handshake ? (rdPtr_q + PTR_ONE) : rdPtr_q;
    end

    // Load sequencing. A slot_start in any state restarts the load, which is
    // how an abort skips the done pulse. Draining finishes only once both the
    // FIFO and the presented beat are gone.
    always_comb begin
        state_d = state_q;
        if (bus.slot_start) begin
            state_d = LOADING;
        end else begin
            unique case (state_q)
                IDLE:     state_d = IDLE;
                LOADING:  if (bus.slot_complete) state_d = DRAINING;
                DRAINING: if (fifoEmpty && !outValid_q) state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Pointer, output stage and status next-state. The output register always
    // shows the FIFO entry at the read pointer; it reloads only when nothing is
    // being held, so the beat stays frozen while the sink stalls. slot_start
    // flushes everything and wins over any same-cycle activity.
    always_comb begin
        wrPtr_d      = pushOk ? (wrPtr_q + PTR_ONE) : wrPtr_q;
        rdPtr_d      = rdNext;
        outValid_d   = (rdNext != wrPtr_q);
        outAddr_d    = outAddr_q;
        outData_d    = outData_q;
        wordCount_d  = wordCount_q + (handshake ? 32'd1 : 32'd0);
        activeSlot_d = activeSlot_q;
        overflow_d   = overflow_q || (pushReq && !pushOk);
        if (outValid_d && (!outValid_q || handshake)) begin
            outAddr_d = fifoAddr[rdNext[PW-1:0]];
            outData_d = fifoData[rdNext[PW-1:0]];
        end
        if (bus.slot_start) begin
            wrPtr_d      = '0;
            rdPtr_d      = '0;
            outValid_d   = 1'b0;
            wordCount_d  = '0;
            overflow_d   = 1'b0;
            activeSlot_d = bus.slot_id;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            outValid_q   <= 1'b0;
            outAddr_q    <= '0;
            outData_q    <= '0;
            wordCount_q  <= '0;
            activeSlot_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            outValid_q   <= outValid_d;
            outAddr_q    <= outAddr_d;
            outData_q    <= outData_d;
            wordCount_q  <= wordCount_d;
            activeSlot_q <= activeSlot_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage has no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoAddr[wrPtr_q[PW-1:0]] <= offset[MEM_AW+1:2];
            fifoData[wrPtr_q[PW-1:0]] <= pushData;
        end
    end

    assign bus.mem_valid   = outValid_q;
    assign bus.mem_addr    = outAddr_q;
    assign bus.mem_data    = outData_q;
    assign bus.word_count  = wordCount_q;
    assign bus.active_slot = activeSlot_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (state_q == LOADING) || (state_q == DRAINING);
    assign bus.done        = (state_q == DONE);

endmodule
